// File: rtl/interrupt_controller.sv
// Priority interrupt controller in front of the CPU: N edge-triggered maskable
// lines plus one NMI, fixed priority (bit 0 highest), one maskable in flight.
// Latency: irq edge at clock k -> pending after k, INT after k+1; NMI after k.
// Backpressure: an offered interrupt holds INT/int_id until ack; a new request
// waits in pending until eoi returns the controller to idle.
// Ports: clk, rst (sync, active-high); irq_in/nmi_in request lines;
//   mask_wr/mask_data mask load; ack/nmi_ack/eoi CPU handshake pulses;
//   INT/NMI/int_id/in_service/pending status outputs (all registered).
module interrupt_controller #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             nmi_in,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_data,
  input  logic             ack,
  input  logic             nmi_ack,
  input  logic             eoi,
  output logic             INT,
  output logic             NMI,
  output logic [ID_W-1:0]  int_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] prev_irq_q, prev_irq_d;
  logic             prev_nmi_q, prev_nmi_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             int_q, int_d;
  logic             nmi_q, nmi_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic             in_service_q, in_service_d;

  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] elig;
  logic             nmi_edge;
  logic [ID_W-1:0]  winner;

  always_comb begin
    irq_edge = irq_in & ~prev_irq_q;
    nmi_edge = nmi_in & ~prev_nmi_q;
    elig     = pending_q & ~mask_q;

    // Scan from the top down so the lowest set index is the one left standing.
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end

    state_d      = state_q;
    pending_d    = pending_q;
    int_d        = int_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    prev_irq_d   = irq_in;
    prev_nmi_d   = nmi_in;

    case (state_q)
      IDLE: begin
        // A pending or just-arriving NMI keeps maskable grants off.
        if ((|elig) && !nmi_q && !nmi_edge) begin
          state_d  = REQ;
          int_d    = 1'b1;
          int_id_d = winner;
        end
      end
      REQ: begin
        // ack wins over a simultaneous NMI edge: the CPU already took it.
        if (ack) begin
          state_d              = SERVICE;
          int_d                = 1'b0;
          in_service_d         = 1'b1;
          pending_d[int_id_q]  = 1'b0;
        end else if (nmi_edge) begin
          state_d = IDLE;
          int_d   = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // New edges are ORed in last so a same-cycle set beats the ack clear.
    pending_d = pending_d | irq_edge;
    nmi_d     = nmi_edge | (nmi_q & ~nmi_ack);
    mask_d    = mask_wr ? mask_data : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      // Lines already high at reset must not look like fresh edges.
      prev_irq_q   <= irq_in;
      prev_nmi_q   <= nmi_in;
      pending_q    <= '0;
      mask_q       <= '0;
      int_q        <= 1'b0;
      nmi_q        <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_irq_q   <= prev_irq_d;
      prev_nmi_q   <= prev_nmi_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_q        <= int_d;
      nmi_q        <= nmi_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign INT        = int_q;
  assign NMI        = nmi_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule
